// File: rtl/mips16_pkg.sv
// Shared constants and types for the mips16 data-memory path.
// Holds the arbiter state encoding and the requester port indices.
package mips16_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int NUM_PORTS = 2;
  localparam int PORT_CPU  = 0;
  localparam int PORT_DBG  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the data-memory arbiter: request vector in, one-hot grant out.
// DATA_MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the CPU port has fixed priority.
import mips16_pkg::*;

module arb_pick (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

`ifdef DATA_MEM_ARB_RR_EN
  // last_i holds the index of the port served most recently; a tie goes to the other one.
  always_comb begin
    gnt_o = '0;
    if (req_i[PORT_CPU] && req_i[PORT_DBG]) begin
      if (last_i == 1'(PORT_DBG)) gnt_o[PORT_CPU] = 1'b1;
      else                        gnt_o[PORT_DBG] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = '0;
    if (req_i[PORT_CPU])      gnt_o[PORT_CPU] = 1'b1;
    else if (req_i[PORT_DBG]) gnt_o[PORT_DBG] = 1'b1;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a synchronous data memory: IDLE -> ISSUE -> CAPT, one access in flight.
// Define DATA_MEM_ARB_RR_EN for round-robin ties; default build gives the CPU fixed priority.
import mips16_pkg::*;

module data_mem_arbiter #(
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              dbg_req,
  input  logic              cpu_we,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_done,
  output logic              dbg_done,
  output logic              cpu_err,
  output logic              dbg_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  arb_state_e state_q, state_d;
  logic                 win_q, win_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [NUM_PORTS-1:0] rd_load;
  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic                 pick_idx;
  logic                 last_served;
  logic                 addr_ok;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_all;

  assign req_vec[PORT_CPU] = cpu_req;
  assign req_vec[PORT_DBG] = dbg_req;
  assign pick_idx          = pick_gnt[PORT_DBG];
  assign addr_ok           = ({1'b0, addr_q} < DEPTH_LIM);

  arb_pick u_pick (
    .req_i  (req_vec),
    .last_i (last_served),
    .gnt_o  (pick_gnt)
  );

`ifdef DATA_MEM_ARB_RR_EN
  logic last_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          last_q <= 1'(PORT_DBG);
    else if (state_q == IDLE && |req_vec) last_q <= pick_idx;
  end
  assign last_served = last_q;
`else
  assign last_served = 1'(PORT_DBG);
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    rd_load = '0;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          we_d    = pick_idx ? dbg_we    : cpu_we;
          addr_d  = pick_idx ? dbg_addr  : cpu_addr;
          wdata_d = pick_idx ? dbg_wdata : cpu_wdata;
          gnt_d   = pick_gnt;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d        = IDLE;
        done_d[win_q]  = 1'b1;
        err_d[win_q]   = !addr_ok;
        rd_load[win_q] = !we_q && addr_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Each port keeps its last good read until that port completes another in-range read.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           rdata_q <= '0;
      else if (rd_load[gi]) rdata_q <= mem_read_data;
    end
    assign rdata_all[gi] = rdata_q;
  end

  // Strobes decode straight from registered state so reset removes them without waiting for a clock.
  assign mem_write_en    = (state_q == ISSUE) && we_q && addr_ok;
  assign mem_read        = (state_q == ISSUE) && !we_q && addr_ok;
  assign mem_access_addr = addr_q;
  assign mem_write_data  = wdata_q;

  assign cpu_gnt   = gnt_q[PORT_CPU];
  assign dbg_gnt   = gnt_q[PORT_DBG];
  assign cpu_done  = done_q[PORT_CPU];
  assign dbg_done  = done_q[PORT_DBG];
  assign cpu_err   = err_q[PORT_CPU];
  assign dbg_err   = err_q[PORT_DBG];
  assign cpu_rdata = rdata_all[PORT_CPU];
  assign dbg_rdata = rdata_all[PORT_DBG];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural synchronous memory.
// Honours DATA_MEM_ARB_RR_EN for the tie-break expectations.
module tb_data_mem_arbiter;

  localparam int DEPTH = 256;
`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, dbg_req, cpu_we, dbg_we;
  logic [15:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
  logic        cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_err, dbg_err;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_we(cpu_we), .dbg_we(dbg_we),
    .cpu_addr(cpu_addr), .dbg_addr(dbg_addr), .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_done(cpu_done), .dbg_done(dbg_done),
    .cpu_err(cpu_err), .dbg_err(dbg_err), .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
    if (mem_read)     mem_read_data <= mem[mem_access_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        err;
    logic [15:0] rdata;
    int          gcyc;
  } exp_t;

  exp_t        sbq[$];
  bit   [15:0] model [DEPTH];
  logic [15:0] exp_rd [2];
  int          last_served;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic sb_push(input int port, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    e.port = port;
    e.err  = (addr >= 16'(DEPTH));
    if (!e.err && we)  model[addr[7:0]] = wdata;
    if (!e.err && !we) exp_rd[port] = model[addr[7:0]];
    e.rdata = exp_rd[port];
    e.gcyc  = cyc;
    sbq.push_back(e);
    last_served = port;
  endtask

  task automatic drive(input int port, input bit req, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    if (port == 0) begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    else           begin dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
  endtask

  task automatic wait_gnt(input int port, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((port == 0 && cpu_gnt) || (port == 1 && dbg_gnt)) begin ok = 1'b1; break; end
    end
  endtask

  // Full transaction: request, wait for grant, record expectation, drop request, wait for done cycle.
  task automatic txn(input int port, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    bit ok;
    drive(port, 1'b1, we, addr, wdata);
    wait_gnt(port, 10, ok);
    n_checks++;
    if (!ok) $display("FAIL txn_gnt port=%0d addr=%h got no grant, required grant", port, addr);
    else begin n_pass++; sb_push(port, we, addr, wdata); end
    drive(port, 1'b0, we, addr, wdata);
    repeat (2) @(negedge clk);
  endtask

  exp_t        mon_e;
  int          mon_port;
  logic        mon_err;
  logic [15:0] mon_rd;

  always @(negedge clk) begin
    if (cpu_gnt || dbg_gnt || cpu_done || dbg_done || cpu_err || dbg_err) begin
      n_checks++;
      if ((cpu_gnt && dbg_gnt) || (cpu_done && dbg_done) || (cpu_err && dbg_err))
        $display("FAIL exclusive gnt=%b%b done=%b%b err=%b%b required at most one port each",
                 cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_err, dbg_err);
      else n_pass++;
    end
    if (cpu_done || dbg_done) begin
      n_checks++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected_done cpu_done=%b dbg_done=%b required no done", cpu_done, dbg_done);
      end else begin
        mon_e    = sbq.pop_front();
        mon_port = dbg_done ? 1 : 0;
        mon_err  = dbg_done ? dbg_err : cpu_err;
        mon_rd   = dbg_done ? dbg_rdata : cpu_rdata;
        if (mon_port != mon_e.port || mon_err !== mon_e.err || mon_rd !== mon_e.rdata || (cyc - mon_e.gcyc) != 2)
          $display("FAIL sb_done port=%0d err=%b rdata=%h lat=%0d required port=%0d err=%b rdata=%h lat=2",
                   mon_port, mon_err, mon_rd, cyc - mon_e.gcyc, mon_e.port, mon_e.err, mon_e.rdata);
        else n_pass++;
      end
    end
  end

  task automatic bench_reset_state();
    sbq.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_served = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    bench_reset_state();
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_err, dbg_err} !== 6'b0)
      $display("FAIL reset_flags gnt/done/err=%b required 000000", {cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_err, dbg_err});
    else n_pass++;
    n_checks++;
    if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0)
      $display("FAIL reset_rdata cpu=%h dbg=%h required 0000 0000", cpu_rdata, dbg_rdata);
    else n_pass++;
    n_checks++;
    if ({mem_write_en, mem_read} !== 2'b0 || mem_access_addr !== 16'h0 || mem_write_data !== 16'h0)
      $display("FAIL reset_mem we=%b rd=%b addr=%h wd=%h required 0 0 0000 0000",
               mem_write_en, mem_read, mem_access_addr, mem_write_data);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    drive(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    wait_gnt(0, 1, ok);
    n_checks++;
    if (!ok || mem_write_en !== 1'b1 || mem_read !== 1'b0 || mem_access_addr !== 16'h0010 || mem_write_data !== 16'hBEEF)
      $display("FAIL write_issue gnt=%b we=%b rd=%b addr=%h wd=%h required 1 1 0 0010 beef",
               cpu_gnt, mem_write_en, mem_read, mem_access_addr, mem_write_data);
    else n_pass++;
    if (ok) sb_push(0, 1'b1, 16'h0010, 16'hBEEF);
    drive(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    n_checks++;
    if (mem_write_en !== 1'b0 || mem_read !== 1'b0 || cpu_gnt !== 1'b0)
      $display("FAIL write_capt we=%b rd=%b gnt=%b required 0 0 0", mem_write_en, mem_read, cpu_gnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0)
      $display("FAIL write_done done=%b err=%b required 1 0", cpu_done, cpu_err);
    else n_pass++;
  endtask

  task automatic test_read();
    bit ok;
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    wait_gnt(0, 1, ok);
    n_checks++;
    if (!ok || mem_read !== 1'b1 || mem_write_en !== 1'b0 || mem_access_addr !== 16'h0010)
      $display("FAIL read_issue gnt=%b rd=%b we=%b addr=%h required 1 1 0 0010",
               cpu_gnt, mem_read, mem_write_en, mem_access_addr);
    else n_pass++;
    if (ok) sb_push(0, 1'b0, 16'h0010, 16'h0);
    drive(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 16'hBEEF)
      $display("FAIL read_done done=%b rdata=%h required 1 beef", cpu_done, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_boundary();
    txn(0, 1'b1, 16'h00FF, 16'h1234);
    txn(1, 1'b0, 16'h00FF, 16'h0);
    txn(1, 1'b0, 16'h0010, 16'h0);
    txn(0, 1'b1, 16'h0020, 16'hA5A5);
    txn(1, 1'b1, 16'h0030, 16'h5A5A);
  endtask

  task automatic test_out_of_range();
    bit ok;
    logic [15:0] held;
    held = dbg_rdata;
    drive(1, 1'b1, 1'b0, 16'h0100, 16'h0);
    wait_gnt(1, 1, ok);
    n_checks++;
    if (!ok || mem_read !== 1'b0 || mem_write_en !== 1'b0)
      $display("FAIL oor_issue gnt=%b rd=%b we=%b required 1 0 0", dbg_gnt, mem_read, mem_write_en);
    else n_pass++;
    if (ok) sb_push(1, 1'b0, 16'h0100, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0100, 16'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_done !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== held)
      $display("FAIL oor_done done=%b err=%b rdata=%h required 1 1 %h", dbg_done, dbg_err, dbg_rdata, held);
    else n_pass++;
    txn(0, 1'b1, 16'hFFFF, 16'hDEAD);
    txn(0, 1'b0, 16'h00FF, 16'h0);
  endtask

  task automatic test_back_to_back();
    int ngr;
    int prev;
    int gport;
    int want;
    bit got;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bench_reset_state();
    drive(0, 1'b1, 1'b0, 16'h0020, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0030, 16'h0);
    prev = 0;
    ngr  = RR ? 4 : 5;
    for (int k = 0; k < ngr; k++) begin
      got = 1'b0;
      for (int t = 0; t < 5 && !got; t++) begin
        @(negedge clk);
        if (cpu_gnt || dbg_gnt) got = 1'b1;
      end
      gport = dbg_gnt ? 1 : 0;
      if (k >= 4)                 want = 1;
      else if (RR)                want = (last_served == 1) ? 0 : 1;
      else                        want = 0;
      n_checks++;
      if (!got || gport != want || (k > 0 && cyc - prev != 3))
        $display("FAIL b2b_grant k=%0d got=%b port=%0d spacing=%0d required port=%0d spacing=3",
                 k, got, gport, cyc - prev, want);
      else n_pass++;
      if (got) sb_push(gport, 1'b0, gport == 1 ? 16'h0030 : 16'h0020, 16'h0);
      prev = cyc;
      if (k == 3) begin
        drive(0, 1'b0, 1'b0, 16'h0020, 16'h0);
        if (RR) drive(1, 1'b0, 1'b0, 16'h0030, 16'h0);
      end
      if (k == 4) drive(1, 1'b0, 1'b0, 16'h0030, 16'h0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw_done;
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    wait_gnt(0, 1, ok);
    drive(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (!ok || mem_read !== 1'b0 || mem_write_en !== 1'b0 || cpu_rdata !== 16'h0)
      $display("FAIL rst_capt gnt_seen=%b rd=%b we=%b rdata=%h required 1 0 0 0000",
               ok, mem_read, mem_write_en, cpu_rdata);
    else n_pass++;
    bench_reset_state();
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_done || dbg_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) $display("FAIL rst_no_done saw_done=1 required 0");
    else n_pass++;
    reset = 1'b1;
    txn(0, 1'b0, 16'h0010, 16'h0);
    // Reset in ISSUE of a write: the write strobe must vanish before the next edge.
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h1111);
    wait_gnt(0, 1, ok);
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h1111);
    reset = 1'b0;
    #1;
    n_checks++;
    if (!ok || mem_write_en !== 1'b0 || cpu_gnt !== 1'b0)
      $display("FAIL rst_issue gnt_seen=%b we=%b gnt=%b required 1 0 0", ok, mem_write_en, cpu_gnt);
    else n_pass++;
    bench_reset_state();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(0, 1'b0, 16'h0010, 16'h0);
  endtask

  task automatic test_drop_and_busy();
    bit ok;
    bit saw;
    drive(0, 1'b1, 1'b1, 16'h0040, 16'h7777);
    wait_gnt(0, 1, ok);
    if (ok) sb_push(0, 1'b1, 16'h0040, 16'h7777);
    drive(0, 1'b0, 1'b1, 16'h0040, 16'h7777);
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'h0010, 16'h0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dbg_gnt) saw = 1'b1;
    end
    n_checks++;
    if (!ok || saw) $display("FAIL drop_no_gnt cpu_gnt_seen=%b dbg_gnt_seen=%b required 1 0", ok, saw);
    else n_pass++;
    drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    wait_gnt(0, 1, ok);
    if (ok) sb_push(0, 1'b0, 16'h0040, 16'h0);
    drive(0, 1'b0, 1'b0, 16'h0040, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h00FF, 16'h0);
    saw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (dbg_gnt) saw = 1'b1;
    end
    n_checks++;
    if (!ok || saw || cpu_done !== 1'b1)
      $display("FAIL busy_hold cpu_gnt_seen=%b early_dbg_gnt=%b cpu_done=%b required 1 0 1", ok, saw, cpu_done);
    else n_pass++;
    wait_gnt(1, 1, ok);
    n_checks++;
    if (!ok) $display("FAIL busy_accept dbg_gnt=%b required 1 in cycle after done", dbg_gnt);
    else begin n_pass++; sb_push(1, 1'b0, 16'h00FF, 16'h0); end
    drive(1, 1'b0, 1'b0, 16'h00FF, 16'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_boundary();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_drop_and_busy();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) $display("FAIL sb_drain pending=%0d required 0", sbq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
